// File: rtl/fib_pkg.sv
// Shared constants and FSM encoding for the Fibonacci index search.
// Latency: n/a (package only).
// Backpressure: n/a.
package fib_pkg;

    localparam int FIB_DATA_W    = 16;
    localparam int FIB_MAX_INDEX = 25;
    // Index counter wide enough for the largest N reachable at FIB_DATA_W.
    localparam int FIB_IDX_W     = $clog2(FIB_MAX_INDEX + 1);

    typedef enum logic [1:0] {
        FIB_IDLE   = 2'd0,
        FIB_SEARCH = 2'd1,
        FIB_DONE   = 2'd2
    } fib_state_e;

endpackage

// File: rtl/fib_index_if.sv
// Request/result bundle for fib_index: start+din in, dout/exact/done/busy out.
// Latency: n/a (wiring only).
// Backpressure: none; start is only honoured while busy is low.
//   start : request pulse          din   : target value T
//   dout  : result index N         exact : F(N) == T
//   done  : one-cycle completion   busy  : request in progress
interface fib_index_if
    import fib_pkg::*;
#(
    parameter int DATA_W = FIB_DATA_W
);
    logic              start;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;
    logic              exact;
    logic              done;
    logic              busy;

    modport master (output start, output din,
                    input  dout,  input  exact, input done, input busy);
    modport slave  (input  start, input  din,
                    output dout,  output exact, output done, output busy);
endinterface

// File: rtl/fib_step.sv
// One Fibonacci step: next = cur + prev, plus compare of cur against target.
// Latency: combinational.
// Backpressure: none.
//   i_cur, i_prev, i_target : current pair and zero-extended target
//   o_next, o_ge, o_eq      : next term, cur >= target, cur == target
module fib_step #(
    parameter int W = 17
) (
    input  logic [W-1:0] i_cur,
    input  logic [W-1:0] i_prev,
    input  logic [W-1:0] i_target,
    output logic [W-1:0] o_next,
    output logic         o_ge,
    output logic         o_eq
);
    assign o_next = i_cur + i_prev;
    assign o_ge   = (i_cur >= i_target);
    assign o_eq   = (i_cur == i_target);
endmodule

// File: rtl/fib_index.sv
// Finds the smallest N with F(N) >= din, flagging whether F(N) == din.
// Latency: done after 1 cycle for din<=1, else 1+N cycles after start.
// Backpressure: start ignored (not queued) while busy.
//   clk, reset : clock, async active-high reset
//   bus        : fib_index_if slave (start/din in; dout/exact/done/busy out)
module fib_index
    import fib_pkg::*;
#(
    parameter int DATA_W = FIB_DATA_W
) (
    input  logic        clk,
    input  logic        reset,
    fib_index_if.slave  bus
);
    localparam logic [1:0] S_IDLE   = FIB_IDLE;
    localparam logic [1:0] S_SEARCH = FIB_SEARCH;
    localparam logic [1:0] S_DONE   = FIB_DONE;

    // One extra bit so the first term past the largest target never wraps.
    localparam int SUM_W = DATA_W + 1;

    logic [1:0]           r_state;
    logic [DATA_W-1:0]    r_target;
    logic [SUM_W-1:0]     r_prev;
    logic [SUM_W-1:0]     r_cur;
    logic [FIB_IDX_W-1:0] r_idx;
    logic [DATA_W-1:0]    r_dout;
    logic                 r_exact;
    logic                 r_done;

    logic [SUM_W-1:0]     w_target_ext;
    logic [SUM_W-1:0]     w_next;
    logic                 w_ge;
    logic                 w_eq;

    assign w_target_ext = {1'b0, r_target};

    fib_step #(.W(SUM_W)) u_step (
        .i_cur    (r_cur),
        .i_prev   (r_prev),
        .i_target (w_target_ext),
        .o_next   (w_next),
        .o_ge     (w_ge),
        .o_eq     (w_eq)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_target <= '0;
            r_prev   <= '0;
            r_cur    <= '0;
            r_idx    <= '0;
            r_dout   <= '0;
            r_exact  <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_target <= bus.din;
                        // F(0)=0 and F(1)=1 answer themselves; skip the search.
                        if (bus.din <= DATA_W'(1)) begin
                            r_dout  <= bus.din;
                            r_exact <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_prev  <= '0;
                            r_cur   <= SUM_W'(1);
                            r_idx   <= FIB_IDX_W'(1);
                            r_state <= S_SEARCH;
                        end
                    end
                end
                S_SEARCH: begin
                    if (w_ge) begin
                        r_dout  <= DATA_W'(r_idx);
                        r_exact <= w_eq;
                        r_state <= S_DONE;
                    end else begin
                        r_prev <= r_cur;
                        r_cur  <= w_next;
                        r_idx  <= r_idx + FIB_IDX_W'(1);
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.dout  = r_dout;
    assign bus.exact = r_exact;
    assign bus.done  = r_done;
    assign bus.busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_fib_index.sv
module tb_fib_index;
    import fib_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    fib_index_if #(.DATA_W(16)) bus ();

    fib_index #(.DATA_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one start pulse and count edges until done; lat=-1 on timeout.
    // din is scrambled after the start edge to show it is latched.
    task automatic do_req(input logic [15:0] t, output int lat);
        @(negedge clk);
        bus.start = 1'b1;
        bus.din   = t;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.din   = 16'hA5A5;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done === 1'b1) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.din   = '0;
        repeat (2) @(negedge clk);
        checks++; if (bus.dout !== 16'd0) begin failures++; $display("FAIL reset_dout got=%0d exp=0", bus.dout); end
        checks++; if (bus.exact !== 1'b0) begin failures++; $display("FAIL reset_exact got=%b exp=0", bus.exact); end
        checks++; if (bus.done !== 1'b0)  begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        checks++; if (bus.busy !== 1'b0)  begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_trivial();
        int lat;
        do_req(16'd0, lat);
        checks++; if (lat !== 1)          begin failures++; $display("FAIL din0_latency got=%0d exp=1", lat); end
        checks++; if (bus.dout !== 16'd0) begin failures++; $display("FAIL din0_dout got=%0d exp=0", bus.dout); end
        checks++; if (bus.exact !== 1'b1) begin failures++; $display("FAIL din0_exact got=%b exp=1", bus.exact); end
        @(negedge clk);
        checks++; if (bus.done !== 1'b0)  begin failures++; $display("FAIL din0_done_width got=%b exp=0", bus.done); end
        do_req(16'd1, lat);
        checks++; if (lat !== 1)          begin failures++; $display("FAIL din1_latency got=%0d exp=1", lat); end
        checks++; if (bus.dout !== 16'd1) begin failures++; $display("FAIL din1_dout got=%0d exp=1", bus.dout); end
        checks++; if (bus.exact !== 1'b1) begin failures++; $display("FAIL din1_exact got=%b exp=1", bus.exact); end
    endtask

    task automatic test_exact_hit();
        int lat;
        do_req(16'd2, lat);
        checks++; if (lat !== 4)          begin failures++; $display("FAIL din2_latency got=%0d exp=4", lat); end
        checks++; if (bus.dout !== 16'd3) begin failures++; $display("FAIL din2_dout got=%0d exp=3", bus.dout); end
        checks++; if (bus.exact !== 1'b1) begin failures++; $display("FAIL din2_exact got=%b exp=1", bus.exact); end
        @(negedge clk);
        checks++; if (bus.done !== 1'b0)  begin failures++; $display("FAIL din2_done_width got=%b exp=0", bus.done); end
        do_req(16'd46368, lat);
        checks++; if (lat !== 25)          begin failures++; $display("FAIL din46368_latency got=%0d exp=25", lat); end
        checks++; if (bus.dout !== 16'd24) begin failures++; $display("FAIL din46368_dout got=%0d exp=24", bus.dout); end
        checks++; if (bus.exact !== 1'b1)  begin failures++; $display("FAIL din46368_exact got=%b exp=1", bus.exact); end
    endtask

    task automatic test_inexact();
        int lat;
        do_req(16'd4, lat);
        checks++; if (lat !== 6)          begin failures++; $display("FAIL din4_latency got=%0d exp=6", lat); end
        checks++; if (bus.dout !== 16'd5) begin failures++; $display("FAIL din4_dout got=%0d exp=5", bus.dout); end
        checks++; if (bus.exact !== 1'b0) begin failures++; $display("FAIL din4_exact got=%b exp=0", bus.exact); end
    endtask

    task automatic test_max();
        int lat;
        do_req(16'hFFFF, lat);
        checks++; if (lat !== FIB_MAX_INDEX + 1) begin failures++; $display("FAIL max_latency got=%0d exp=26", lat); end
        checks++; if (bus.dout !== 16'd25)       begin failures++; $display("FAIL max_dout got=%0d exp=25", bus.dout); end
        checks++; if (bus.exact !== 1'b0)        begin failures++; $display("FAIL max_exact got=%b exp=0", bus.exact); end
    endtask

    task automatic test_ignore_start();
        int lat;
        int busy_bad;
        int extra_done;
        int dout_bad;
        @(negedge clk);
        bus.start = 1'b1;
        bus.din   = 16'd10;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.din   = 16'd0;
        lat = -1;
        busy_bad = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done === 1'b1) begin
                lat = c;
                bus.start = 1'b0;
                break;
            end
            if (bus.busy !== 1'b1) busy_bad++;
            // Stray request mid-search; must neither restart nor queue.
            if (c == 2) begin
                bus.start = 1'b1;
                bus.din   = 16'd1;
            end else begin
                bus.start = 1'b0;
            end
        end
        checks++; if (lat !== 8)          begin failures++; $display("FAIL ign_latency got=%0d exp=8", lat); end
        checks++; if (bus.dout !== 16'd7) begin failures++; $display("FAIL ign_dout got=%0d exp=7", bus.dout); end
        checks++; if (bus.exact !== 1'b0) begin failures++; $display("FAIL ign_exact got=%b exp=0", bus.exact); end
        checks++; if (busy_bad !== 0)     begin failures++; $display("FAIL ign_busy low_cycles=%0d exp=0", busy_bad); end
        extra_done = 0;
        dout_bad   = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) extra_done++;
            if (bus.dout !== 16'd7 || bus.exact !== 1'b0) dout_bad++;
        end
        checks++; if (extra_done !== 0) begin failures++; $display("FAIL ign_no_queue bad_cycles=%0d exp=0", extra_done); end
        checks++; if (dout_bad !== 0)   begin failures++; $display("FAIL ign_hold bad_cycles=%0d exp=0", dout_bad); end
    endtask

    task automatic test_reset_mid_search();
        int lat;
        int spurious;
        @(negedge clk);
        bus.start = 1'b1;
        bus.din   = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL rst_mid_pre_busy got=%b exp=1", bus.busy); end
        reset = 1'b1;
        #1;
        checks++; if (bus.dout !== 16'd0) begin failures++; $display("FAIL rst_mid_dout got=%0d exp=0", bus.dout); end
        checks++; if (bus.exact !== 1'b0) begin failures++; $display("FAIL rst_mid_exact got=%b exp=0", bus.exact); end
        checks++; if (bus.busy !== 1'b0)  begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.done !== 1'b0)  begin failures++; $display("FAIL rst_mid_done got=%b exp=0", bus.done); end
        @(negedge clk);
        reset = 1'b0;
        spurious = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.done !== 1'b0) spurious++;
        end
        checks++; if (spurious !== 0) begin failures++; $display("FAIL rst_mid_no_done cycles=%0d exp=0", spurious); end
        do_req(16'd5, lat);
        checks++; if (lat !== 6)          begin failures++; $display("FAIL after_rst_latency got=%0d exp=6", lat); end
        checks++; if (bus.dout !== 16'd5) begin failures++; $display("FAIL after_rst_dout got=%0d exp=5", bus.dout); end
        checks++; if (bus.exact !== 1'b1) begin failures++; $display("FAIL after_rst_exact got=%b exp=1", bus.exact); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_trivial();
        test_exact_hit();
        test_inexact();
        test_max();
        test_ignore_start();
        test_reset_mid_search();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
